// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer (master) and the datapath (slave).
interface mc_ctrl_if #(
  parameter int OPCODE_WIDTH     = 6,
  parameter int FUNCT_WIDTH      = 6,
  parameter int ALUCONTROL_WIDTH = 3,
  parameter int STATE_WIDTH      = 4
);
  logic [OPCODE_WIDTH-1:0]     OpCode;
  logic [FUNCT_WIDTH-1:0]      Funct;
  logic                        Zero_flag;
  logic                        mem_ready;
  logic                        IorD;
  logic                        MemRead;
  logic                        MemWrite;
  logic                        IRWrite;
  logic                        RegDst;
  logic                        MemtoReg;
  logic                        RegWrite;
  logic                        ALUSrcA;
  logic [1:0]                  ALUSrcB;
  logic [ALUCONTROL_WIDTH-1:0] ALUControl;
  logic [1:0]                  PCSrc;
  logic                        PCEn;
  logic                        illegal_op;
  logic [STATE_WIDTH-1:0]      state_o;

  modport master (
    input  OpCode, Funct, Zero_flag, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, state_o
  );

  modport slave (
    output OpCode, Funct, Zero_flag, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, state_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer (fetch/decode/execute/memory/writeback) with memory-ready stalls.
// Optional retire/stall performance counters when MC_CTRL_PERF_CNT_EN is defined.
module mc_control_fsm #(
  parameter int OPCODE_WIDTH     = 6,
  parameter int FUNCT_WIDTH      = 6,
  parameter int ALUCONTROL_WIDTH = 3,
  parameter int STATE_WIDTH      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_ctrl_if.master    bus
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]  instr_retired,
  output logic [31:0]  stall_cycles
`endif
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic                        iord;
    logic                        mem_read;
    logic                        mem_write;
    logic                        ir_write;
    logic                        reg_dst;
    logic                        memto_reg;
    logic                        reg_write;
    logic                        alu_src_a;
    logic [1:0]                  alu_src_b;
    logic [ALUCONTROL_WIDTH-1:0] alu_control;
    logic [1:0]                  pc_src;
    logic                        pc_en;
    logic                        illegal_op;
  } ctrl_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'b000010;

  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SUB = 3'b100;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SLT = 3'b110;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_MUL = 3'b101;

  function automatic logic [ALUCONTROL_WIDTH-1:0] alu_from_funct(
    input logic [FUNCT_WIDTH-1:0] funct
  );
    case (funct)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b101010: return ALU_SLT;
      6'b011100: return ALU_MUL;
      default:   return ALU_ADD;
    endcase
  endfunction

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = ALU_ADD;
        ctrl.ir_write    = bus.mem_ready;
        ctrl.pc_en       = bus.mem_ready;
        if (bus.mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        // Speculatively compute the branch target while the opcode is decoded.
        ctrl.alu_src_b   = 2'b11;
        ctrl.alu_control = ALU_ADD;
        case (bus.OpCode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default: begin
            state_nxt       = FETCH;
            ctrl.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = 2'b10;
        ctrl.alu_control = ALU_ADD;
        if (state == ADDIEX)           state_nxt = ADDIWB;
        else if (bus.OpCode == OP_LW)  state_nxt = MEMRD;
        else                           state_nxt = MEMWR;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (bus.mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        ctrl.memto_reg = 1'b1;
        ctrl.reg_write = 1'b1;
        state_nxt      = FETCH;
      end
      MEMWR: begin
        // Strobe is held through the wait; memory commits on the ready cycle.
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (bus.mem_ready) state_nxt = FETCH;
      end
      EXEC: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = alu_from_funct(bus.Funct);
        state_nxt        = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_nxt      = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_src      = 2'b01;
        ctrl.pc_en       = bus.Zero_flag;
        state_nxt        = FETCH;
      end
      ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_nxt      = FETCH;
      end
      JUMP: begin
        ctrl.pc_src = 2'b10;
        ctrl.pc_en  = 1'b1;
        state_nxt   = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Everything is forced quiet while reset is held, including FETCH's read request.
  ctrl_t ctrl_q;
  assign ctrl_q = rst_n ? ctrl : '0;

  assign bus.IorD       = ctrl_q.iord;
  assign bus.MemRead    = ctrl_q.mem_read;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.IRWrite    = ctrl_q.ir_write;
  assign bus.RegDst     = ctrl_q.reg_dst;
  assign bus.MemtoReg   = ctrl_q.memto_reg;
  assign bus.RegWrite   = ctrl_q.reg_write;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ALUControl = ctrl_q.alu_control;
  assign bus.PCSrc      = ctrl_q.pc_src;
  assign bus.PCEn       = ctrl_q.pc_en;
  assign bus.illegal_op = ctrl_q.illegal_op;
  assign bus.state_o    = state;

`ifdef MC_CTRL_PERF_CNT_EN
  logic retire;
  logic stall;

  // DECODE -> FETCH is the illegal-op path and does not retire.
  assign retire = (state_nxt == FETCH) &&
                  (state inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP});
  assign stall  = (state inside {FETCH, MEMRD, MEMWR}) && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (retire) instr_retired <= instr_retired + 32'd1;
      if (stall)  stall_cycles  <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed table-driven bench for mc_control_fsm, plus hand-written reset and counter sequences.
module tb_mc_control_fsm;

  logic clk;
  logic rst_n;

  mc_ctrl_if bus ();

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instr_retired;
  logic [31:0] stall_cycles;
`endif

  mc_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .instr_retired (instr_retired),
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] ILL = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011100;
  localparam logic [5:0] F_OTH = 6'b000111;

  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,illegal_op}
  localparam logic [16:0] W_RST   = 17'b0_0_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [16:0] W_FET1  = 17'b0_1_0_1_0_0_0_0_01_010_00_1_0;
  localparam logic [16:0] W_FET0  = 17'b0_1_0_0_0_0_0_0_01_010_00_0_0;
  localparam logic [16:0] W_DEC   = 17'b0_0_0_0_0_0_0_0_11_010_00_0_0;
  localparam logic [16:0] W_DECIL = 17'b0_0_0_0_0_0_0_0_11_010_00_0_1;
  localparam logic [16:0] W_MADR  = 17'b0_0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [16:0] W_MRD   = 17'b1_1_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [16:0] W_MWB   = 17'b0_0_0_0_0_1_1_0_00_000_00_0_0;
  localparam logic [16:0] W_MWR   = 17'b1_0_1_0_0_0_0_0_00_000_00_0_0;
  localparam logic [16:0] W_EXADD = 17'b0_0_0_0_0_0_0_1_00_010_00_0_0;
  localparam logic [16:0] W_EXSUB = 17'b0_0_0_0_0_0_0_1_00_100_00_0_0;
  localparam logic [16:0] W_EXSLT = 17'b0_0_0_0_0_0_0_1_00_110_00_0_0;
  localparam logic [16:0] W_EXMUL = 17'b0_0_0_0_0_0_0_1_00_101_00_0_0;
  localparam logic [16:0] W_AWB   = 17'b0_0_0_0_1_0_1_0_00_000_00_0_0;
  localparam logic [16:0] W_BR1   = 17'b0_0_0_0_0_0_0_1_00_100_01_1_0;
  localparam logic [16:0] W_BR0   = 17'b0_0_0_0_0_0_0_1_00_100_01_0_0;
  localparam logic [16:0] W_AIEX  = 17'b0_0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [16:0] W_AIWB  = 17'b0_0_0_0_0_0_1_0_00_000_00_0_0;
  localparam logic [16:0] W_JMP   = 17'b0_0_0_0_0_0_0_0_00_000_10_1_0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] w;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic logic [16:0] get_word();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUControl, bus.PCSrc, bus.PCEn, bus.illegal_op};
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] f, input logic z,
                     input logic mr, input logic [3:0] st, input logic [16:0] w);
    vecs.push_back('{op, f, z, mr, st, w});
  endtask

  task automatic check(input string name, input logic [3:0] est, input logic [16:0] ew);
    logic [16:0] aw;
    aw = get_word();
    n_vec++;
    if (bus.state_o !== est || aw !== ew) begin
      n_bad++;
      $display("FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
               name, bus.state_o, aw, est, ew);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] f, input logic z, input logic mr);
    bus.OpCode    = op;
    bus.Funct     = f;
    bus.Zero_flag = z;
    bus.mem_ready = mr;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // R-type sub; opcode changes after DECODE must be ignored
    add(RT,  6'd0,  0, 1, 0,  W_FET1);
    add(RT,  6'd0,  0, 1, 1,  W_DEC);
    add(ILL, F_SUB, 0, 1, 6,  W_EXSUB);
    add(ILL, F_ADD, 0, 1, 7,  W_AWB);
    // lw with two memory stalls: 7 cycles total
    add(LW,  6'd0,  0, 1, 0,  W_FET1);
    add(LW,  6'd0,  0, 1, 1,  W_DEC);
    add(LW,  6'd0,  0, 1, 2,  W_MADR);
    add(SW,  6'd0,  0, 0, 3,  W_MRD);
    add(SW,  6'd0,  0, 0, 3,  W_MRD);
    add(LW,  6'd0,  0, 1, 3,  W_MRD);
    add(LW,  6'd0,  0, 1, 4,  W_MWB);
    // beq taken / not taken
    add(BEQ, 6'd0,  1, 1, 0,  W_FET1);
    add(BEQ, 6'd0,  1, 1, 1,  W_DEC);
    add(BEQ, 6'd0,  1, 1, 8,  W_BR1);
    add(BEQ, 6'd0,  0, 1, 0,  W_FET1);
    add(BEQ, 6'd0,  0, 1, 1,  W_DEC);
    add(BEQ, 6'd0,  0, 1, 8,  W_BR0);
    // illegal opcode, then jump
    add(ILL, 6'd0,  0, 1, 0,  W_FET1);
    add(ILL, 6'd0,  0, 1, 1,  W_DECIL);
    add(JMP, 6'd0,  0, 1, 0,  W_FET1);
    add(JMP, 6'd0,  0, 1, 1,  W_DEC);
    add(JMP, 6'd0,  0, 1, 11, W_JMP);
    // sw with one stall in MEMWR
    add(SW,  6'd0,  0, 1, 0,  W_FET1);
    add(SW,  6'd0,  0, 1, 1,  W_DEC);
    add(SW,  6'd0,  0, 1, 2,  W_MADR);
    add(SW,  6'd0,  0, 0, 5,  W_MWR);
    add(SW,  6'd0,  0, 1, 5,  W_MWR);
    // addi
    add(ADI, 6'd0,  0, 1, 0,  W_FET1);
    add(ADI, 6'd0,  0, 1, 1,  W_DEC);
    add(ADI, 6'd0,  0, 1, 9,  W_AIEX);
    add(ADI, 6'd0,  0, 1, 10, W_AIWB);
    // slt with a fetch stall, then mul, add, unknown funct
    add(RT,  F_SLT, 0, 0, 0,  W_FET0);
    add(RT,  F_SLT, 0, 1, 0,  W_FET1);
    add(RT,  F_SLT, 0, 1, 1,  W_DEC);
    add(RT,  F_SLT, 0, 1, 6,  W_EXSLT);
    add(RT,  F_SLT, 0, 1, 7,  W_AWB);
    add(RT,  F_MUL, 0, 1, 0,  W_FET1);
    add(RT,  F_MUL, 0, 1, 1,  W_DEC);
    add(RT,  F_MUL, 0, 1, 6,  W_EXMUL);
    add(RT,  F_MUL, 0, 1, 7,  W_AWB);
    add(RT,  F_ADD, 0, 1, 0,  W_FET1);
    add(RT,  F_ADD, 0, 1, 1,  W_DEC);
    add(RT,  F_ADD, 0, 1, 6,  W_EXADD);
    add(RT,  F_ADD, 0, 1, 7,  W_AWB);
    add(RT,  F_OTH, 0, 1, 0,  W_FET1);
    add(RT,  F_OTH, 0, 1, 1,  W_DEC);
    add(RT,  F_OTH, 0, 1, 6,  W_EXADD);
    add(RT,  F_OTH, 0, 1, 7,  W_AWB);
    add(RT,  6'd0,  0, 1, 0,  W_FET1);

    // Reset held for three clocks with mem_ready high: everything quiet
    rst_n = 1'b0;
    drive(RT, 6'd0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_hold", 4'd0, W_RST);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
      #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].w);
      @(negedge clk);
    end

    // Reset asserted asynchronously in the middle of a stalled store
    drive(SW, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("sw_before_reset", 4'd5, W_MWR);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'd0, W_RST);
    @(negedge clk);
    #1;
    check("reset_held_sw", 4'd0, W_RST);
    rst_n = 1'b1;
    #1;
    check("release_stalled", 4'd0, W_FET0);

`ifdef MC_CTRL_PERF_CNT_EN
    begin
      logic [5:0] p_op[13];
      logic       p_mr[13];
      p_op = '{LW, LW, LW, LW, LW, LW, LW, SW, SW, SW, SW, ILL, ILL};
      p_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (instr_retired !== 32'd0 || stall_cycles !== 32'd0) begin
        n_bad++;
        $display("FAIL perf_reset: retired=%0d stalls=%0d, expected 0 and 0",
                 instr_retired, stall_cycles);
      end
      @(negedge clk);
      bus.mem_ready = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 13; c++) begin
        drive(p_op[c], 6'd0, 1'b0, p_mr[c]);
        @(negedge clk);
      end
      #1;
      check("perf_end_state", 4'd0, W_FET1);
      n_vec++;
      if (instr_retired !== 32'd2 || stall_cycles !== 32'd2) begin
        n_bad++;
        $display("FAIL perf_counts: retired=%0d stalls=%0d, expected 2 and 2",
                 instr_retired, stall_cycles);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
